// File: rtl/pic_pkg.sv
// Shared widths, constants and fetch-sequencer state encodings for the PIC core.
package pic_pkg;

  localparam int PC_W    = 9;
  localparam int INSTR_W = 12;

  localparam logic [INSTR_W-1:0] NOP_INSTR     = 12'h000;
  localparam logic [PC_W-1:0]    RESET_VEC_DEF = 9'h000;

  // Fetch sequencer states: one fill cycle after reset, then steady state.
  typedef enum logic {
    ST_RESET_FILL = 1'b0,
    ST_RUN        = 1'b1
  } fetch_st_t;

  // Sequential program counter step; 9-bit arithmetic wraps 511 -> 0.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/pic_ret_stack.sv
// Hardware return stack: circular buffer with a saturating occupancy count.
// Pushing when full overwrites the oldest entry. Popping when empty returns
// the stale entry under the pointer and leaves pointer and count unchanged.
// ovf/unf are single-cycle event strobes; the caller keeps them sticky.
module pic_ret_stack
  import pic_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] dout,
  output logic            ovf,
  output logic            unf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_dec;
  logic [CNT_W-1:0] count_reg;
  logic             full;
  logic             empty;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign ptr_dec = ptr_reg - PTR_W'(1);
  assign ovf     = push & full;
  assign unf     = pop & empty;

  // Top of stack sits just below the pointer; an empty stack exposes the slot at the pointer.
  assign dout = empty ? mem[ptr_reg] : mem[ptr_dec];

  // Entry storage is never reset; only pointer and count are.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Write the slot addressed by the pointer on a push.
      always_ff @(posedge clk) begin
        if (push && (ptr_reg == PTR_W'(gi))) begin
          mem[gi] <= din;
        end
      end
    end
  endgenerate

  // Pointer advances on every push; count saturates at DEPTH and floors at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else if (push) begin
      ptr_reg <= ptr_reg + PTR_W'(1);
      if (!full) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      ptr_reg   <= ptr_dec;
      count_reg <= count_reg - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pic_fetch_ctrl.sv
// Instruction-fetch sequencer: program counter, instruction register,
// redirect priority mux with one-bubble flush, and return-stack flags.
module pic_fetch_ctrl
  import pic_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VEC   = RESET_VEC_DEF,
  parameter int              STACK_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               stall,
  input  logic               jump,
  input  logic               call,
  input  logic               ret,
  input  logic               skip,
  input  logic [PC_W-1:0]    target,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    instr_pc,
  output logic               stk_ovf,
  output logic               stk_unf,
  output logic               redir_err
);

  fetch_st_t          st_reg;
  logic [PC_W-1:0]    pc_reg;
  logic [PC_W-1:0]    pc_next;
  logic [INSTR_W-1:0] instr_reg;
  logic               valid_reg;
  logic [PC_W-1:0]    instr_pc_reg;
  logic               ovf_reg;
  logic               unf_reg;
  logic               redir_err_reg;

  logic               sample;
  logic               ret_sel;
  logic               call_sel;
  logic               jump_sel;
  logic               skip_sel;
  logic               redir_any;
  logic               multi_redir;
  logic [PC_W-1:0]    stk_dout;
  logic               stk_ovf_evt;
  logic               stk_unf_evt;

  // Redirects only count while a real instruction is executing and not stalled.
  assign sample      = ~stall & valid_reg & (st_reg == ST_RUN);
  assign ret_sel     = sample & ret;
  assign call_sel    = sample & call & ~ret;
  assign jump_sel    = sample & jump & ~ret & ~call;
  assign skip_sel    = sample & skip & ~ret & ~call & ~jump;
  assign redir_any   = ret_sel | call_sel | jump_sel | skip_sel;
  assign multi_redir = sample & ($countones({ret, call, jump, skip}) > 1);

  // Next PC: popped return address, branch target, or sequential (skip also just steps).
  always_comb begin
    pc_next = pc_inc(pc_reg);
    if (ret_sel) begin
      pc_next = stk_dout;
    end else if (call_sel || jump_sel) begin
      pc_next = target;
    end
  end

  pic_ret_stack #(
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (call_sel),
    .pop   (ret_sel),
    .din   (pc_reg),
    .dout  (stk_dout),
    .ovf   (stk_ovf_evt),
    .unf   (stk_unf_evt)
  );

  // Fetch FSM: fill the instruction register once after reset, then fetch or flush each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_reg        <= ST_RESET_FILL;
      pc_reg        <= RESET_VEC;
      instr_reg     <= NOP_INSTR;
      valid_reg     <= 1'b0;
      instr_pc_reg  <= RESET_VEC;
      redir_err_reg <= 1'b0;
    end else begin
      redir_err_reg <= multi_redir;
      if (!stall) begin
        case (st_reg)
          ST_RESET_FILL: begin
            instr_reg    <= rom_data;
            instr_pc_reg <= pc_reg;
            valid_reg    <= 1'b1;
            pc_reg       <= pc_inc(pc_reg);
            st_reg       <= ST_RUN;
          end
          ST_RUN: begin
            instr_pc_reg <= pc_reg;
            pc_reg       <= pc_next;
            if (redir_any) begin
              instr_reg <= NOP_INSTR;
              valid_reg <= 1'b0;
            end else begin
              instr_reg <= rom_data;
              valid_reg <= 1'b1;
            end
          end
          default: st_reg <= ST_RESET_FILL;
        endcase
      end
    end
  end

  // Stack error flags stay set until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      if (stk_ovf_evt) ovf_reg <= 1'b1;
      if (stk_unf_evt) unf_reg <= 1'b1;
    end
  end

  assign rom_addr    = pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = valid_reg;
  assign instr_pc    = instr_pc_reg;
  assign stk_ovf     = ovf_reg;
  assign stk_unf     = unf_reg;
  assign redir_err   = redir_err_reg;

endmodule

// File: tb/tb_pic_fetch_ctrl.sv
// Directed bench for pic_fetch_ctrl with a small behavioural ROM.
module tb_pic_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [8:0]  rom_addr;
  logic [11:0] rom_data;
  logic        stall;
  logic        jump;
  logic        call;
  logic        ret;
  logic        skip;
  logic [8:0]  target;
  logic [11:0] instr;
  logic        instr_valid;
  logic [8:0]  instr_pc;
  logic        stk_ovf;
  logic        stk_unf;
  logic        redir_err;

  int checks = 0;
  int errors = 0;

  pic_fetch_ctrl #(
    .RESET_VEC   (9'h000),
    .STACK_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .stall       (stall),
    .jump        (jump),
    .call        (call),
    .ret         (ret),
    .skip        (skip),
    .target      (target),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_pc    (instr_pc),
    .stk_ovf     (stk_ovf),
    .stk_unf     (stk_unf),
    .redir_err   (redir_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program ROM: a few fixed words, everything else {3'b111, address}.
  function automatic logic [11:0] rom_word(input logic [8:0] a);
    case (a)
      9'd0:    return 12'hC09;
      9'd1:    return 12'h028;
      9'd6:    return 12'hC06;
      9'd12:   return 12'hC03;
      9'd25:   return 12'h200;
      9'd40:   return 12'hA1B;
      default: return {3'b111, a};
    endcase
  endfunction

  always_comb rom_data = rom_word(rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; jump = 1'b0; call = 1'b0;
    ret = 1'b0; skip = 1'b0; target = 9'd0;
    #12;
    // Reset state
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_instr", 32'(instr), 32'h000);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);
    check("rst_flags", 32'({stk_ovf, stk_unf, redir_err}), 32'd0);
    rst_n = 1'b1;
    step();
    check("fill_instr", 32'(instr), 32'hC09);
    check("fill_instr_pc", 32'(instr_pc), 32'd0);
    check("fill_valid", 32'(instr_valid), 32'd1);
    check("fill_rom_addr", 32'(rom_addr), 32'd1);
    $display("tb: reset fill instr=%h pc=%0d", instr, instr_pc);
    step();
    check("seq_instr", 32'(instr), 32'h028);
    check("seq_instr_pc", 32'(instr_pc), 32'd1);

    // Jump to 25
    jump = 1'b1; target = 9'd25;
    step();
    jump = 1'b0;
    check("jmp_bubble_instr", 32'(instr), 32'h000);
    check("jmp_bubble_valid", 32'(instr_valid), 32'd0);
    check("jmp_rom_addr", 32'(rom_addr), 32'd25);
    step();
    check("jmp_instr", 32'(instr), 32'h200);
    check("jmp_instr_pc", 32'(instr_pc), 32'd25);
    check("jmp_valid", 32'(instr_valid), 32'd1);
    $display("tb: jump -> instr=%h pc=%0d", instr, instr_pc);

    // Reach address 5, then call 40 and return
    jump = 1'b1; target = 9'd5;
    step();
    jump = 1'b0;
    step();
    check("at5_instr_pc", 32'(instr_pc), 32'd5);
    call = 1'b1; target = 9'd40;
    step();
    call = 1'b0;
    check("call_bubble_valid", 32'(instr_valid), 32'd0);
    step();
    check("call_instr", 32'(instr), 32'hA1B);
    check("call_instr_pc", 32'(instr_pc), 32'd40);
    ret = 1'b1;
    step();
    ret = 1'b0;
    check("ret_rom_addr", 32'(rom_addr), 32'd6);
    step();
    check("ret_instr", 32'(instr), 32'hC06);
    check("ret_instr_pc", 32'(instr_pc), 32'd6);
    check("ret_count", 32'(dut.u_stack.count_reg), 32'd0);
    $display("tb: call/ret -> instr=%h pc=%0d", instr, instr_pc);

    // Three nested calls on a two-entry stack (return addresses 7, 101, 201)
    call = 1'b1; target = 9'd100;
    step(); call = 1'b0; step();
    check("nest1_pc", 32'(instr_pc), 32'd100);
    call = 1'b1; target = 9'd200;
    step(); call = 1'b0; step();
    check("nest2_pc", 32'(instr_pc), 32'd200);
    check("ovf_before", 32'(stk_ovf), 32'd0);
    call = 1'b1; target = 9'd300;
    step(); call = 1'b0;
    check("ovf_set", 32'(stk_ovf), 32'd1);
    step();
    check("nest3_pc", 32'(instr_pc), 32'd300);
    ret = 1'b1; step(); ret = 1'b0; step();
    check("pop1_pc", 32'(instr_pc), 32'd201);
    ret = 1'b1; step(); ret = 1'b0; step();
    check("pop2_pc", 32'(instr_pc), 32'd101);
    check("unf_before", 32'(stk_unf), 32'd0);
    ret = 1'b1; step(); ret = 1'b0;
    check("unf_set", 32'(stk_unf), 32'd1);
    step();
    check("pop3_pc", 32'(instr_pc), 32'd101);
    check("pop3_instr", 32'(instr), 32'hE65);
    $display("tb: nested calls ovf=%b unf=%b", stk_ovf, stk_unf);

    // Skip at address 10
    jump = 1'b1; target = 9'd10;
    step(); jump = 1'b0; step();
    check("at10_pc", 32'(instr_pc), 32'd10);
    skip = 1'b1;
    step();
    skip = 1'b0;
    check("skip_bubble_valid", 32'(instr_valid), 32'd0);
    step();
    check("skip_instr_pc", 32'(instr_pc), 32'd12);
    check("skip_instr", 32'(instr), 32'hC03);
    $display("tb: skip -> instr=%h pc=%0d", instr, instr_pc);

    // Stall for three cycles with a pending jump
    stall = 1'b1; jump = 1'b1; target = 9'd25;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_rom_addr", 32'(rom_addr), 32'd13);
      check("stall_instr", 32'(instr), 32'hC03);
    end
    stall = 1'b0;
    step();
    jump = 1'b0;
    check("unstall_rom_addr", 32'(rom_addr), 32'd25);
    step();
    check("unstall_instr", 32'(instr), 32'h200);
    check("sticky_flags", 32'({stk_ovf, stk_unf}), 32'b11);
    $display("tb: stall then jump -> instr=%h pc=%0d", instr, instr_pc);

    // Jump and skip together: jump wins, error pulses once
    check("err_idle", 32'(redir_err), 32'd0);
    jump = 1'b1; skip = 1'b1; target = 9'd50;
    step();
    jump = 1'b0; skip = 1'b0;
    check("multi_rom_addr", 32'(rom_addr), 32'd50);
    check("multi_err", 32'(redir_err), 32'd1);
    step();
    check("multi_err_clear", 32'(redir_err), 32'd0);
    check("multi_instr_pc", 32'(instr_pc), 32'd50);
    $display("tb: jump+skip -> pc=%0d", instr_pc);

    // PC wrap from 511 to 0
    jump = 1'b1; target = 9'd510;
    step(); jump = 1'b0; step();
    check("wrap_rom_addr_511", 32'(rom_addr), 32'd511);
    step();
    check("wrap_instr_pc", 32'(instr_pc), 32'd511);
    check("wrap_rom_addr_0", 32'(rom_addr), 32'd0);
    $display("tb: wrap -> rom_addr=%0d", rom_addr);

    // Asynchronous reset mid-run, away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rom_addr", 32'(rom_addr), 32'd0);
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_flags", 32'({stk_ovf, stk_unf, redir_err}), 32'd0);
    check("arst_count", 32'(dut.u_stack.count_reg), 32'd0);
    $display("tb: async reset -> rom_addr=%0d", rom_addr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic_fetch_ctrl.md
# pic_fetch_ctrl

Instruction-fetch sequencer for the structural PIC core. Owns the 9-bit program counter, drives the combinational program ROM address, and latches the returned 12-bit word into the instruction register. It also applies redirects from execute (jump, call, return, skip) with a one-slot pipeline flush, and maintains the hardware return stack. It sits between `pic_rom` and the decode/execute stage.

## Interface
- `RESET_VEC`, 9'h000: PC value after reset.
- `STACK_DEPTH`, 2: return-stack entries. Must be a power of two, at least 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rom_addr`  out  9  ROM address. Equals `pc`.
- `rom_data`  in  12  ROM word. Combinational from `rom_addr`, valid in the same cycle.
- `stall`  in  1  freezes all state.
- `jump`  in  1  one-cycle redirect to `target`.
- `call`  in  1  pushes the return address, then redirects to `target`.
- `ret`  in  1  pops the return stack into the PC.
- `skip`  in  1  discards the instruction currently being fetched.
- `target`  in  9  destination for `jump` and `call`.
- `instr`  out  12  instruction register.
- `instr_valid`  out  1  `instr` holds a real fetched word, not a bubble.
- `instr_pc`  out  9  ROM address `instr` was fetched from.
- `stk_ovf`  out  1  sticky: a push was made with the stack full.
- `stk_unf`  out  1  sticky: a pop was made with the stack empty.
- `redir_err`  out  1  one-cycle pulse: more than one redirect input was asserted.

## Operation
- Pipeline model: `instr` holds the instruction at address A, which is executing. `pc` = A+1 is being fetched.
- Normal cycle (stall=0, no redirect):
  - `instr` <= `rom_data`; `instr_pc` <= `pc`; `instr_valid` <= 1.
  - `pc` <= `pc`+1, modulo 512 (511 wraps to 0).
- Redirect cycle: `instr` <= NOP (12'h000); `instr_valid` <= 0; `instr_pc` <= `pc`. The next PC depends on the redirect:
  - `jump`: `pc` <= `target`.
  - `call`: push `pc` (return address A+1), then `pc` <= `target`.
  - `ret`: `pc` <= popped entry.
  - `skip`: `pc` <= `pc`+1, so A+1 is discarded and A+2 is fetched next.
- Redirect priority: `ret` > `call` > `jump` > `skip`. Any two or more asserted together → the highest wins and `redir_err` pulses the following cycle.
- Redirect inputs are sampled only when `instr_valid`=1. Redirects arriving during a bubble are ignored, because no real instruction is executing.
- `stall`=1 holds `pc`, `instr`, `instr_valid`, `instr_pc` and the stack, and ignores all redirect inputs. Execute must hold its redirect request until `stall` drops. `rom_addr` stays stable.
- Return stack: circular buffer plus a saturating occupancy count 0..STACK_DEPTH.
  - Push when full overwrites the oldest entry and sets `stk_ovf`.
  - Pop when empty returns the entry under the pointer (stale data, matching baseline PIC wrap behaviour), leaves the count at 0, and sets `stk_unf`.
- FSM `st`: RESET_FILL → RUN.
  - RESET_FILL lasts exactly the first clock after reset release. It loads `rom_data` at RESET_VEC.
  - RUN is the steady state.
  - Flush bubbles are carried by `instr_valid` and do not need an extra state.

## Timing
- Reset values:
  - `pc`=`rom_addr`=RESET_VEC
  - `instr`=12'h000, `instr_valid`=0, `instr_pc`=RESET_VEC
  - stack pointer=0, count=0
  - `stk_ovf`=`stk_unf`=`redir_err`=0
  - `st`=RESET_FILL
- Fetch latency: 1 clock from `rom_addr` to `instr`.
- Redirect penalty: exactly 1 bubble cycle. The target instruction appears in `instr` 2 edges after the redirect edge.
- Reset asserted mid-run clears everything immediately, with no clock needed. The stack contents themselves need not be cleared; only the pointer and count reset.
- Back-to-back redirects are impossible, since the bubble blocks sampling.
- Call immediately followed by a return at the target is legal: ret is sampled once the target instruction is valid.

## Structure
- Shared `pic_pkg`:
  - widths `PC_W`=9 and `INSTR_W`=12
  - `NOP_INSTR`=12'h000
  - `RESET_VEC` default
  - FSM state encodings
- Sub-module `pic_ret_stack`:
  - inputs: `push`, `pop`, `din[8:0]`
  - outputs: `dout[8:0]`, `ovf`, `unf`
  - parameter `DEPTH`
  - carries the same clock/reset
- The top level contains the PC, the instruction register, the priority mux and the sticky flags.

## Test plan
- Reset release with `pic_rom` attached → `rom_addr`=0. After one edge: `instr`=12'hC09, `instr_pc`=0, `instr_valid`=1, `rom_addr`=1. Next edge: `instr`=12'h028.
- `jump` with `target`=9'd25 while `instr_valid`=1 → one cycle with `instr`=12'h000 and `instr_valid`=0. Then `instr`=12'h200 with `instr_pc`=25.
- `call` with `target`=9'd40 at `instr_pc`=5 → `instr` becomes 12'hA1B at `instr_pc`=40. A following `ret` resumes at `instr_pc`=6 (`instr`=12'hC06), and the stack count returns to 0.
- Three nested calls with STACK_DEPTH=2 → `stk_ovf`=1. Three returns → the second-oldest address is reused and `stk_unf`=1. Both flags stay set until `rst_n`=0.
- `skip` at `instr_pc`=10 → bubble, then `instr_pc`=12 (`instr`=12'hC03). Separately, `stall` held 3 cycles with `jump` asserted → `pc`/`instr` unchanged, and the jump is taken on the first unstalled cycle.
- `jump` and `skip` together → jump wins and `redir_err` pulses once. PC at 511 with no redirect → `rom_addr` wraps to 0.
